// File: rtl/rf_access_ctrl_if.sv
// Issue-side bundle of the register-file access controller: operand requests,
// operand responses and writeback. Every channel transfers on a clock edge where valid & ready are both high.
interface rf_access_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_src1;
  logic [ADDR_WIDTH-1:0] req_src2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data1;
  logic [WIDTH-1:0]      rsp_data2;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic                  init_done;

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready, wb_valid, wb_addr, wb_data,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2, wb_ready, init_done
  );

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready, wb_valid, wb_addr, wb_data,
    output req_ready, rsp_valid, rsp_data1, rsp_data2, wb_ready, init_done
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: zero-fills the RF after reset, then serves
// 2-operand reads (with same-cycle writeback forwarding) and muxes writebacks.
module rf_access_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  rf_access_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] rf_addr_rd1,
  output logic [ADDR_WIDTH-1:0] rf_addr_rd2,
  output logic [ADDR_WIDTH-1:0] rf_addr_wr,
  output logic                  rf_wr_enable,
  output logic [WIDTH-1:0]      rf_wr,
  input  logic [WIDTH-1:0]      rf_rd1,
  input  logic [WIDTH-1:0]      rf_rd2,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  clearing;
  logic                  run;

  logic                  live;
  logic                  clr_we;
  logic                  run_live;
  logic                  wb_fire;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            occ_after_pop;

  logic                  s1_valid_q;
  logic                  byp1_q, byp2_q;
  logic [WIDTH-1:0]      byp_data_q;
  logic [WIDTH-1:0]      s1_data1, s1_data2;

  logic [WIDTH-1:0]      fifo_d1_q [2];
  logic [WIDTH-1:0]      fifo_d2_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            count_q;

  // INIT already performs the address-0 write once reset is low, so the sweep
  // lands on cycles 1..SIZE and RUN begins on cycle SIZE+1.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    clearing = 1'b0;
    run      = 1'b0;
    case (state_q)
      ST_INIT: begin
        clearing = 1'b1;
        sweep_d  = sweep_q + ADDR_WIDTH'(1);
        state_d  = ST_CLEAR;
      end
      ST_CLEAR: begin
        clearing = 1'b1;
        sweep_d  = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Every externally visible control is forced to its idle value while reset is high.
  assign live         = !reset;
  assign clr_we       = clearing & live;
  assign run_live     = run & live;
  assign wb_fire      = bus.wb_valid & run_live;

  assign bus.wb_ready  = run_live;
  assign bus.init_done = run_live;
  assign rf_wr_enable  = clr_we | wb_fire;
  assign rf_addr_wr    = run_live ? bus.wb_addr : (clr_we ? sweep_q : '0);
  assign rf_wr         = run_live ? bus.wb_data : '0;
  assign rf_addr_rd1   = bus.req_src1;
  assign rf_addr_rd2   = bus.req_src2;
  assign dbg_state_o   = state_q;

  // A slot is reserved for every request in flight, so S1 never meets a full FIFO.
  assign bus.rsp_valid = (count_q != 2'd0) & live;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign occ           = {1'b0, s1_valid_q} + count_q;
  assign occ_after_pop = occ - {1'b0, pop};
  assign bus.req_ready = run_live & (occ_after_pop < 2'd2);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = s1_valid_q & live;

  assign s1_data1 = byp1_q ? byp_data_q : rf_rd1;
  assign s1_data2 = byp2_q ? byp_data_q : rf_rd2;

  assign bus.rsp_data1 = bus.rsp_valid ? fifo_d1_q[rptr_q] : '0;
  assign bus.rsp_data2 = bus.rsp_valid ? fifo_d2_q[rptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        byp1_q <= wb_fire & (bus.wb_addr == bus.req_src1);
        byp2_q <= wb_fire & (bus.wb_addr == bus.req_src2);
      end
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (accept) byp_data_q <= bus.wb_data;
    if (push) begin
      fifo_d1_q[wptr_q] <= s1_data1;
      fifo_d2_q[wptr_q] <= s1_data2;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a registered-read RF model, an
// expected-response queue and a monitor that checks every popped response.
module tb_rf_access_ctrl;
  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rf_addr_rd1, rf_addr_rd2, rf_addr_wr;
  logic          rf_wr_enable;
  logic [W-1:0]  rf_wr, rf_rd1, rf_rd2;
  logic [1:0]    dbg_state;

  rf_access_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  rf_access_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .rf_addr_rd1  (rf_addr_rd1),
    .rf_addr_rd2  (rf_addr_rd2),
    .rf_addr_wr   (rf_addr_wr),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr        (rf_wr),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset / RF model ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Un-reset array with garbage contents so the zero-fill is observable.
  logic [W-1:0] rf_mem [8] = '{32'hBAD0_0000, 32'hBAD0_0001, 32'hBAD0_0002, 32'hBAD0_0003,
                               32'hBAD0_0004, 32'hBAD0_0005, 32'hBAD0_0006, 32'hBAD0_0007};
  always @(posedge clk) begin
    rf_rd1 <= rf_mem[rf_addr_rd1];
    rf_rd2 <= rf_mem[rf_addr_rd2];
    if (rf_wr_enable) rf_mem[rf_addr_wr] <= rf_wr;
  end

  // ---------------- scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  int           tries;
  logic [2*W-1:0] exp_q[$];
  int           pop_cyc_q[$];

  // Contents of the RF once the writebacks before the streaming phase have landed.
  logic [W-1:0] mem_exp [8] = '{32'h0000_0000, 32'h1000_00A1, 32'h1000_00A2, 32'h1000_00A3,
                                32'h1000_00A4, 32'hCAFE_F00D, 32'h6666_6666, 32'h0000_0000};
  logic [W-1:0] bp_val [4] = '{32'h1000_00A1, 32'h1000_00A2, 32'h1000_00A3, 32'h1000_00A4};

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  initial begin : monitor
    logic        hold;
    logic [63:0] held;
    logic [63:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold && !reset) begin
        check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_hold_data", {bus.rsp_data1, bus.rsp_data2}, held);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        pop_cyc_q.push_back(cycle);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got %h expected no response (cycle %0d)",
                   {bus.rsp_data1, bus.rsp_data2}, cycle);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", {bus.rsp_data1, bus.rsp_data2}, e);
        end
      end
      hold = bus.rsp_valid && !bus.rsp_ready && !reset;
      held = {bus.rsp_data1, bus.rsp_data2};
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [W-1:0] e1, input logic [W-1:0] e2, output int n_try);
    bus.req_valid = 1'b1;
    bus.req_src1  = s1;
    bus.req_src2  = s2;
    n_try = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_try++;
      if (bus.req_ready) begin
        exp_q.push_back({e1, e2});
        tick();
        return;
      end
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL req_accept_timeout: src %0d/%0d not accepted, required acceptance within 20 cycles", s1, s2);
  endtask

  task automatic wb_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
    @(negedge clk);
    check("wb_ready", 64'(bus.wb_ready), 64'd1);
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    exp_q.delete();
  endtask

  // Called right after reset deasserts; the next negedge belongs to cycle 1.
  task automatic check_sweep();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("clr_we", 64'(rf_wr_enable), 64'd1);
      check("clr_addr", 64'(rf_addr_wr), 64'(c));
      check("clr_data", 64'(rf_wr), 64'd0);
      check("clr_req_ready", 64'(bus.req_ready), 64'd0);
      check("clr_wb_ready", 64'(bus.wb_ready), 64'd0);
      check("clr_init_done", 64'(bus.init_done), 64'd0);
      check("clr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    @(negedge clk);
    check("init_done", 64'(bus.init_done), 64'd1);
    check("run_req_ready", 64'(bus.req_ready), 64'd1);
    check("run_we_idle", 64'(rf_wr_enable), 64'd0);
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stimulus
    int idx;
    bus.req_valid = 1'b0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.rsp_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_wb_ready", 64'(bus.wb_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_we", 64'(rf_wr_enable), 64'd0);
    check("rst_addr_wr", 64'(rf_addr_wr), 64'd0);
    check("rst_rsp_data", {bus.rsp_data1, bus.rsp_data2}, 64'd0);
    tick();
    reset = 1'b0;
    check_sweep();

    // Write then read, response two cycles after the accept
    wb_write(3'd5, 32'hDEAD_BEEF);
    issue_req(3'd5, 3'd0, 32'hDEAD_BEEF, 32'h0, tries);
    bus.req_valid = 1'b0;
    check("wr_rd_accept_tries", 64'(tries), 64'd1);
    @(negedge clk);
    check("lat_acc_plus1", 64'(bus.rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("lat_acc_plus2", 64'(bus.rsp_valid), 64'd1);
    tick();
    drain();

    // Same-cycle forwarding on both ports
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 3'd3;
    bus.wb_data  = 32'h0000_1234;
    issue_req(3'd3, 3'd3, 32'h0000_1234, 32'h0000_1234, tries);
    bus.wb_valid  = 1'b0;
    bus.req_valid = 1'b0;
    drain();

    // Snapshot: a writeback one cycle after the accept must not leak in
    issue_req(3'd5, 3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, tries);
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_addr   = 3'd5;
    bus.wb_data   = 32'hCAFE_F00D;
    tick();
    bus.wb_valid = 1'b0;
    issue_req(3'd5, 3'd3, 32'hCAFE_F00D, 32'h0000_1234, tries);
    bus.req_valid = 1'b0;
    drain();

    // Backpressure: only two accepts while rsp_ready is low
    wb_write(3'd1, 32'h1000_00A1);
    wb_write(3'd2, 32'h1000_00A2);
    wb_write(3'd3, 32'h1000_00A3);
    wb_write(3'd4, 32'h1000_00A4);
    wb_write(3'd6, 32'h6666_6666);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_src2  = 3'd6;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req_src1 = AW'(idx + 1);
      @(negedge clk);
      if (bus.req_ready && idx < 4) begin
        exp_q.push_back({bp_val[idx], 32'h6666_6666});
        idx++;
      end
      tick();
    end
    check("bp_accepts", 64'(idx), 64'd2);
    bus.rsp_ready = 1'b1;
    bus.req_src1  = AW'(idx + 1);
    @(negedge clk);
    check("bp_ready_return", 64'(bus.req_ready), 64'd1);
    if (bus.req_ready && idx < 4) begin
      exp_q.push_back({bp_val[idx], 32'h6666_6666});
      idx++;
    end
    tick();
    for (int c = 0; c < 10 && idx < 4; c++) begin
      bus.req_src1 = AW'(idx + 1);
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back({bp_val[idx], 32'h6666_6666});
        idx++;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd4);
    drain();

    // Full-rate streaming
    pop_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      issue_req(AW'(i % 8), AW'(7 - (i % 8)), mem_exp[i % 8], mem_exp[7 - (i % 8)], tries);
      check("stream_no_stall", 64'(tries), 64'd1);
    end
    bus.req_valid = 1'b0;
    drain();
    check("stream_pop_count", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16)
      check("stream_consecutive", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);

    // Reset with two responses pending
    bus.rsp_ready = 1'b0;
    issue_req(3'd1, 3'd2, 32'h1000_00A1, 32'h1000_00A2, tries);
    issue_req(3'd3, 3'd4, 32'h1000_00A3, 32'h1000_00A4, tries);
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    check("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_init_done", 64'(bus.init_done), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    reset = 1'b0;
    check_sweep();
    issue_req(3'd1, 3'd5, 32'h0, 32'h0, tries);
    issue_req(3'd3, 3'd6, 32'h0, 32'h0, tries);
    bus.req_valid = 1'b0;
    drain();

    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
